// File: rtl/uart_tx7.sv
// 7E1 UART transmitter: start, 7 data bits LSB first, even parity, one stop bit.
// State | meaning: IDLE line high | START start bit | DATA data bits | PARITY parity bit | STOP stop bit.
module uart_tx7 #(
  parameter int bowd_rate  = 9600,
  parameter int clk_length = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] data_in,
  input  logic       send,
  input  logic       par_err,
  output logic       ready,
  output logic       tx_bit,
  output logic       busy,
  output logic       done
);

  localparam int          BIT_CLKS = (1000000000 / bowd_rate) / clk_length;
  localparam logic [31:0] BIT_LAST = 32'(BIT_CLKS - 1);

  if (BIT_CLKS < 2) begin : g_bit_clks_chk
    $error("uart_tx7: BIT_CLKS must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [31:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [6:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        buf_full_q, buf_full_d;
  logic [6:0]  buf_data_q, buf_data_d;
  logic        buf_par_q, buf_par_d;
  logic        tx_bit_q, tx_bit_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic bit_end;
  logic load;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_par_d  = buf_par_q;
    tx_bit_d   = 1'b1;
    busy_d     = (state_q != S_IDLE);
    done_d     = 1'b0;
    load       = 1'b0;
    bit_end    = (clk_cnt_q == BIT_LAST);

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? 32'd0 : clk_cnt_q + 32'd1;
    end

    // Outputs are registered from the current state, so the line trails the FSM by one cycle.
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = 32'd0;
        if (buf_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_bit_d = 1'b0;
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        tx_bit_d = shift_q[bit_idx_q];
        if (bit_end) begin
          if (bit_idx_q == 3'd6) state_d = S_PARITY;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        tx_bit_d = par_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (buf_full_q) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d    = buf_data_q;
      par_d      = buf_par_q;
      buf_full_d = 1'b0;
    end

    // Load needs a full buffer and accept needs an empty one, so they never coincide.
    if (send && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_data_d = data_in;
      buf_par_d  = (^data_in) ^ par_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= 32'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 7'd0;
      par_q      <= 1'b0;
      buf_full_q <= 1'b0;
      buf_data_q <= 7'd0;
      buf_par_q  <= 1'b0;
      tx_bit_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      buf_par_q  <= buf_par_d;
      tx_bit_q   <= tx_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ready  = ~buf_full_q;
  assign tx_bit = tx_bit_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_tx7.sv
// Bench for uart_tx7: frame-level timing model plus directed literal checks and random traffic.
module tb_uart_tx7;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] data_in;
  logic       send;
  logic       par_err;
  logic       ready;
  logic       tx_bit;
  logic       busy;
  logic       done;

  uart_tx7 #(.bowd_rate(1000000), .clk_length(100)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .send   (send),
    .par_err(par_err),
    .ready  (ready),
    .tx_bit (tx_bit),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int e      = 0;
  bit armed  = 1'b0;

  // Model: a frame occupies the line for cycles [start, start+99], bit k during [start+10k, start+10k+9].
  int         f_start = -1000;
  int         p_start = -1000;
  logic [9:0] f_bits  = '1;
  logic [9:0] p_bits  = '1;
  bit         b_valid = 1'b0;
  logic [9:0] b_bits  = '1;
  int         b_load  = 0;

  function automatic logic [9:0] frame_of(input logic [6:0] d, input logic pe);
    return {1'b1, (^d) ^ pe, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s at cycle %0d: got %b, required %b", name, e, act, exp);
    end
  endtask

  // Model update on every edge and per-cycle compare at the following negedge.
  initial begin
    logic       r, s, pe, rdy_prev, x_tx, x_busy, x_done;
    logic [6:0] d;
    forever begin
      @(posedge clk);
      r = rst; s = send; d = data_in; pe = par_err;
      e++;
      if (r) begin
        armed   = 1'b1;
        f_start = -1000;
        p_start = -1000;
        b_valid = 1'b0;
      end else if (armed) begin
        rdy_prev = !b_valid;
        if (b_valid && e == b_load) begin
          p_start = f_start;
          p_bits  = f_bits;
          f_start = e + 1;
          f_bits  = b_bits;
          b_valid = 1'b0;
        end
        if (s && rdy_prev) begin
          b_valid = 1'b1;
          b_bits  = frame_of(d, pe);
          b_load  = (e + 1 > f_start + 99) ? e + 1 : f_start + 99;
        end
      end
      @(negedge clk);
      if (armed) begin
        x_tx = 1'b1; x_busy = 1'b0; x_done = 1'b0;
        if (e >= f_start && e <= f_start + 99) begin
          x_tx = f_bits[(e - f_start) / 10]; x_busy = 1'b1; x_done = (e == f_start + 99);
        end else if (e >= p_start && e <= p_start + 99) begin
          x_tx = p_bits[(e - p_start) / 10]; x_busy = 1'b1; x_done = (e == p_start + 99);
        end
        check("model_tx_bit", tx_bit, x_tx);
        check("model_busy", busy, x_busy);
        check("model_done", done, x_done);
        check("model_ready", ready, !b_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    while (e < target) tick();
  endtask

  task automatic send_word(input logic [6:0] d, input logic pe, output int acc);
    int n = 0;
    while (ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) begin
      ntests++;
      nfail++;
      $display("FAIL send_wait: ready=%b after 400 cycles, required 1", ready);
    end
    data_in = d; par_err = pe; send = 1'b1;
    tick();
    acc  = e;
    send = 1'b0;
  endtask

  task automatic check_frame(input string name, input int start, input logic [9:0] exp_bits);
    for (int k = 0; k < 10; k++) begin
      wait_cycle(start + 10 * k + 5);
      check($sformatf("%s_bit%0d", name, k), tx_bit, exp_bits[k]);
    end
  endtask

  initial begin
    int a1, a2, a3, pct;
    rst = 1'b1; send = 1'b0; data_in = 7'd0; par_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (50) tick();
    check("idle_tx", tx_bit, 1'b1);
    check("idle_ready", ready, 1'b1);
    check("idle_busy", busy, 1'b0);

    send_word(7'h55, 1'b0, a1);
    check("lat_acc", tx_bit, 1'b1);
    wait_cycle(a1 + 1); check("lat_plus1", tx_bit, 1'b1);
    wait_cycle(a1 + 2); check("lat_fall", tx_bit, 1'b0);
    check_frame("f55", a1 + 2, 10'b1_0_1010101_0);
    wait_cycle(a1 + 100); check("f55_done_early", done, 1'b0);
    wait_cycle(a1 + 101); check("f55_done", done, 1'b1);
    wait_cycle(a1 + 102); check("f55_done_after", done, 1'b0);
    check("f55_busy_after", busy, 1'b0);

    repeat (5) tick();
    send_word(7'h01, 1'b1, a1);
    check_frame("f01_perr", a1 + 2, 10'b1_0_0000001_0);
    wait_cycle(a1 + 105);

    send_word(7'h7F, 1'b0, a1);
    wait_cycle(a1 + 20);
    send_word(7'h00, 1'b0, a2);
    check("b2b_ready_low", ready, 1'b0);
    data_in = 7'h2A; par_err = 1'b0; send = 1'b1;
    repeat (15) tick();
    send = 1'b0;
    wait_cycle(a1 + 87);  check("f7F_parity", tx_bit, 1'b1);
    wait_cycle(a1 + 101); check("f7F_done", done, 1'b1);
    check("f7F_stop", tx_bit, 1'b1);
    wait_cycle(a1 + 102); check("b2b_start_no_gap", tx_bit, 1'b0);
    check("b2b_busy", busy, 1'b1);
    wait_cycle(a1 + 187); check("f00_parity", tx_bit, 1'b0);
    wait_cycle(a1 + 201); check("f00_done", done, 1'b1);
    wait_cycle(a1 + 202); check("f00_busy_after", busy, 1'b0);
    wait_cycle(a1 + 260); check("ignored_2A_busy", busy, 1'b0);
    check("ignored_2A_tx", tx_bit, 1'b1);

    send_word(7'h33, 1'b0, a1);
    wait_cycle(a1 + 10);
    send_word(7'h4C, 1'b1, a2);
    wait_cycle(a1 + 2 + 44);
    check("f33_data_bit3", tx_bit, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tx", tx_bit, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    repeat (150) tick();
    check("rst_discard_busy", busy, 1'b0);
    send_word(7'h2A, 1'b0, a3);
    check_frame("f2A_after_rst", a3 + 2, 10'b1_1_0101010_0);
    wait_cycle(a3 + 110);

    pct = 0;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) pct = $urandom_range(0, 80);
      send    = ($urandom_range(0, 999) < pct);
      data_in = 7'($urandom);
      par_err = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 999) == 0);
      tick();
    end
    send = 1'b0; rst = 1'b0;
    repeat (250) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx7.md
Name: uart_tx7

Overview:
- Serial transmitter for the 7-bit UART frame: start bit, 7 data bits LSB first, even parity bit, one stop bit. Idle line is high.
- Drives the line consumed by the receiver block and shares its baud/clock-period parameters, so bit timing matches.
- Parallel side uses a valid/ready handshake with a one-entry holding buffer, so back-to-back frames go out with no idle gap.

Parameters:
- bowd_rate, 9600, line rate in bits/s.
- clk_length, 60, clk period in ns.
- Derived constant BIT_CLKS = (1000000000/bowd_rate)/clk_length, integer division; 1736 at defaults. Required: BIT_CLKS >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  7  parallel byte to send.
- send  input  1  valid; a word transfers on a clk edge where send && ready.
- par_err  input  1  sampled with data_in; 1 = transmit inverted (wrong) parity for that frame.
- ready  output  1  holding buffer empty; can accept a word.
- tx_bit  output  1  serial line, registered.
- busy  output  1  a frame is on the line (START..STOP).
- done  output  1  one-cycle pulse on the last clk of each stop bit.

Behaviour:
- Reset, one clk edge with rst=1: tx_bit=1, ready=1, busy=0, done=0, state IDLE, holding buffer empty, bit counter and clk counter cleared. Reset mid-frame aborts at once; the line returns high the next cycle and the buffered word is discarded.
- Holding buffer: {data, parity}, with parity = (^data_in) ^ par_err computed at acceptance.
- Accept on send && ready: buffer becomes full and ready=0 from the next cycle. send while ready=0 is ignored, with no effect.
- States:
  - IDLE: tx_bit=1. If the buffer is full, move it into the shift register, empty the buffer and go to START. The transition and the buffer load happen on the same edge.
  - START: tx_bit=0 for BIT_CLKS cycles.
  - DATA: 7 bits, bit 0 first, each held BIT_CLKS cycles; a 3-bit index counts 0..6.
  - PARITY: the stored parity bit for BIT_CLKS cycles.
  - STOP: tx_bit=1 for BIT_CLKS cycles, with done=1 in the final cycle. If the buffer is full at that final cycle, load it and go directly to START (no idle cycle). Otherwise go to IDLE.
- Latency: word accepted at edge N from IDLE with the buffer empty. The buffer is full after N, the frame loads at N+1 and tx_bit falls at N+2. Total frame length is exactly 10*BIT_CLKS cycles.
- Simultaneous events:
  - Acceptance on the same edge the buffer is drained into the shift register is not possible, because ready=0 while the buffer is full.
  - A word can be accepted on the same cycle as done; it is then sent back-to-back if it lands in the buffer before the STOP exit edge. Otherwise it waits one IDLE cycle.
- busy=1 in START/DATA/PARITY/STOP, 0 in IDLE.
- The clk counter counts 0..BIT_CLKS-1; the bit boundary is at BIT_CLKS-1, where the counter wraps to 0. It is wide enough for BIT_CLKS (32 bits).
- Inputs are sampled only at acceptance; data_in/par_err changes afterwards do not affect the frame in flight.

Test Plan:
Use bowd_rate=1000000, clk_length=100, so BIT_CLKS=10.
- Reset, then idle 50 cycles -> tx_bit=1, ready=1, busy=0, done never asserted.
- send 7'h55 once -> tx_bit falls 2 cycles after acceptance. Sample at bit centres: 0,1,0,1,0,1,0,1 then parity 0, then stop 1. Each bit is 10 cycles, the frame 100 cycles, and done pulses once at cycle 100 of the frame.
- send 7'h01 with par_err=1 -> parity bit 0 (correct parity would be 1); looped into the receiver, this sets broken=1.
- Back-to-back: send 7'h7F, then 7'h00 while busy -> ready drops after the second accept. The second start bit follows the first stop bit with zero idle cycles. Parity bits are 1 then 0, and done pulses twice, 100 cycles apart.
- send asserted while ready=0 with 7'h2A -> ignored; only the buffered word is sent.
- Assert rst during DATA bit 3 -> tx_bit=1 and busy=0 the next cycle. The buffered word is not sent, and a fresh send afterwards produces a clean frame.
